// File: rtl/seq_pattern_detector.sv
// Serial bit-pattern detector with a runtime-loadable pattern, length and overlap mode.
// Produces a registered match pulse, a saturating match count, and a pulse on rejected configuration.
module seq_pattern_detector #(
   parameter int                 MAX_LEN     = 8,
   parameter int                 CNT_W       = 8,
   parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(8'b0001_0101),
   parameter int                 DEF_LEN     = 5,
   parameter bit                 DEF_OVERLAP = 1'b1,
   localparam int                LEN_W       = $clog2(MAX_LEN + 1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   input  logic               input_data,
   input  logic               cfg_load,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic               cfg_overlap,
   input  logic               clear,
   output logic               sequence_detected,
   output logic [CNT_W-1:0]   match_count,
   output logic               cfg_err
);

   typedef enum logic {
      FILL = 1'b0,
      HUNT = 1'b1
   } state_t;

   state_t             state_reg;
   logic [MAX_LEN-1:0] hist_reg;
   logic [LEN_W-1:0]   fill_reg;
   logic [MAX_LEN-1:0] pattern_reg;
   logic [LEN_W-1:0]   len_reg;
   logic               overlap_reg;
   logic               sequence_detected_reg;
   logic [CNT_W-1:0]   match_count_reg;
   logic               cfg_err_reg;

   logic [MAX_LEN-1:0] hist_next;
   logic [LEN_W-1:0]   fill_next;
   logic [MAX_LEN-1:0] len_mask;
   logic               reached;
   logic               bits_equal;
   logic               match;
   logic               cfg_ok;

   // Only the low len bits of the history take part in the compare.
   for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_len_mask
      assign len_mask[gi] = (LEN_W'(gi) < len_reg);
   end

   assign hist_next  = {hist_reg[MAX_LEN-2:0], input_data};
   assign fill_next  = (fill_reg == LEN_W'(MAX_LEN)) ? fill_reg : fill_reg + LEN_W'(1);
   assign reached    = (state_reg == HUNT) || (fill_next >= len_reg);
   assign bits_equal = (((hist_next ^ pattern_reg) & len_mask) == '0);
   assign match      = reached && bits_equal;
   assign cfg_ok     = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg             <= FILL;
         hist_reg              <= '0;
         fill_reg              <= '0;
         pattern_reg           <= DEF_PATTERN;
         len_reg               <= LEN_W'(DEF_LEN);
         overlap_reg           <= DEF_OVERLAP;
         sequence_detected_reg <= 1'b0;
         match_count_reg       <= '0;
         cfg_err_reg           <= 1'b0;
      end else begin
         sequence_detected_reg <= 1'b0;
         cfg_err_reg           <= 1'b0;
         if (cfg_load) begin
            if (cfg_ok) begin
               pattern_reg <= cfg_pattern;
               len_reg     <= cfg_len;
               overlap_reg <= cfg_overlap;
               fill_reg    <= '0;
               state_reg   <= FILL;
            end else begin
               cfg_err_reg <= 1'b1;
            end
         end else if (clear) begin
            hist_reg        <= '0;
            fill_reg        <= '0;
            match_count_reg <= '0;
            state_reg       <= FILL;
         end else if (in_valid) begin
            hist_reg <= hist_next;
            if (match) begin
               sequence_detected_reg <= 1'b1;
               if (match_count_reg != {CNT_W{1'b1}}) begin
                  match_count_reg <= match_count_reg + CNT_W'(1);
               end
               // Non-overlap flushes the fill so the next match needs len fresh bits.
               if (overlap_reg) begin
                  fill_reg  <= fill_next;
                  state_reg <= HUNT;
               end else begin
                  fill_reg  <= '0;
                  state_reg <= FILL;
               end
            end else begin
               fill_reg  <= fill_next;
               state_reg <= reached ? HUNT : FILL;
            end
         end
      end
   end

   assign sequence_detected = sequence_detected_reg;
   assign match_count       = match_count_reg;
   assign cfg_err           = cfg_err_reg;

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Scenario bench for seq_pattern_detector with a 2-bit match counter.
// Expected outputs are queued with each driven cycle and compared after the edge.
module tb_seq_pattern_detector;

   logic       clk;
   logic       reset;
   logic       in_valid;
   logic       input_data;
   logic       cfg_load;
   logic [7:0] cfg_pattern;
   logic [3:0] cfg_len;
   logic       cfg_overlap;
   logic       clear;
   logic       sequence_detected;
   logic [1:0] match_count;
   logic       cfg_err;

   int tests_run    = 0;
   int tests_failed = 0;

   typedef struct {
      logic  det;
      int    cnt;
      logic  err;
      string tag;
   } exp_t;

   exp_t exp_q[$];

   seq_pattern_detector #(
      .MAX_LEN    (8),
      .CNT_W      (2),
      .DEF_PATTERN(8'b0001_0101),
      .DEF_LEN    (5),
      .DEF_OVERLAP(1'b1)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .in_valid         (in_valid),
      .input_data       (input_data),
      .cfg_load         (cfg_load),
      .cfg_pattern      (cfg_pattern),
      .cfg_len          (cfg_len),
      .cfg_overlap      (cfg_overlap),
      .clear            (clear),
      .sequence_detected(sequence_detected),
      .match_count      (match_count),
      .cfg_err          (cfg_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive, queue the expectation, then compare after the edge.
   task automatic drive(input logic v, input logic d, input logic ld, input logic clr,
                        input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                        input logic e_det, input int e_cnt, input logic e_err, input string tag);
      exp_t e;
      in_valid    = v;
      input_data  = d;
      cfg_load    = ld;
      clear       = clr;
      cfg_pattern = pat;
      cfg_len     = len;
      cfg_overlap = ovl;
      exp_q.push_back('{det: e_det, cnt: e_cnt, err: e_err, tag: tag});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      cfg_load = 1'b0;
      clear    = 1'b0;
      e = exp_q.pop_front();
      $display("[TB] %s: det=%0b cnt=%0d err=%0b", e.tag, sequence_detected, match_count, cfg_err);
      check_eq({e.tag, ".det"}, 32'(sequence_detected), 32'(e.det));
      check_eq({e.tag, ".cnt"}, 32'(match_count), 32'(e.cnt));
      check_eq({e.tag, ".err"}, 32'(cfg_err), 32'(e.err));
   endtask

   task automatic sample(input logic v, input logic d, input logic e_det, input int e_cnt,
                         input string tag);
      drive(v, d, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, e_det, e_cnt, 1'b0, tag);
   endtask

   task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                       input logic e_err, input int e_cnt, input string tag);
      drive(1'b1, 1'b1, 1'b1, 1'b0, pat, len, ovl, 1'b0, e_cnt, e_err, tag);
   endtask

   task automatic do_clear(input string tag);
      drive(1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 4'd0, 1'b0, 1'b0, 0, 1'b0, tag);
   endtask

   initial begin
      reset       = 1'b0;
      in_valid    = 1'b0;
      input_data  = 1'b0;
      cfg_load    = 1'b0;
      cfg_pattern = 8'h00;
      cfg_len     = 4'd0;
      cfg_overlap = 1'b0;
      clear       = 1'b0;
      #12;
      check_eq("rst.det", 32'(sequence_detected), 32'd0);
      check_eq("rst.cnt", 32'(match_count), 32'd0);
      check_eq("rst.err", 32'(cfg_err), 32'd0);
      @(negedge clk);
      reset = 1'b1;

      // Default 10101, overlapping: pulses after bits 5 and 7.
      sample(1, 1, 0, 0, "def_b1");
      sample(1, 0, 0, 0, "def_b2");
      sample(1, 1, 0, 0, "def_b3");
      sample(1, 0, 0, 0, "def_b4");
      sample(1, 1, 1, 1, "def_b5");
      sample(1, 0, 0, 1, "def_b6");
      sample(1, 1, 1, 2, "def_b7");
      do_clear("clr1");

      // Gaps between accepted bits; data during gaps must be ignored.
      sample(1, 1, 0, 0, "gap_b1");
      sample(0, 1, 0, 0, "gap_g1");
      sample(1, 0, 0, 0, "gap_b2");
      sample(0, 1, 0, 0, "gap_g2");
      sample(1, 1, 0, 0, "gap_b3");
      sample(0, 1, 0, 0, "gap_g3");
      sample(1, 0, 0, 0, "gap_b4");
      sample(0, 1, 0, 0, "gap_g4");
      sample(1, 1, 1, 1, "gap_b5");
      sample(0, 1, 0, 1, "gap_g5");
      do_clear("clr2");

      // Rejected loads: no flush, coincident sample discarded, detection continues.
      sample(1, 1, 0, 0, "bad_b1");
      sample(1, 0, 0, 0, "bad_b2");
      sample(1, 1, 0, 0, "bad_b3");
      load(8'h06, 4'd0, 1'b0, 1'b1, 0, "bad_len0");
      sample(1, 0, 0, 0, "bad_b4");
      load(8'h06, 4'd9, 1'b0, 1'b1, 0, "bad_len9");
      sample(1, 1, 1, 1, "bad_b5");
      do_clear("clr3");

      // Pattern 110, len 3, non-overlapping.
      load(8'b0000_0110, 4'd3, 1'b0, 1'b0, 0, "p110_load");
      sample(1, 1, 0, 0, "p110_b1");
      sample(1, 1, 0, 0, "p110_b2");
      sample(1, 0, 1, 1, "p110_b3");
      sample(1, 1, 0, 1, "p110_b4");
      sample(1, 1, 0, 1, "p110_b5");
      sample(1, 0, 1, 2, "p110_b6");
      sample(1, 1, 0, 2, "p110_b7");
      sample(1, 0, 0, 2, "p110_b8");
      do_clear("clr4");

      // Pattern 101 non-overlapping: shared suffix must not start a new match.
      load(8'b0000_0101, 4'd3, 1'b0, 1'b0, 0, "p101_load");
      sample(1, 1, 0, 0, "p101_b1");
      sample(1, 0, 0, 0, "p101_b2");
      sample(1, 1, 1, 1, "p101_b3");
      sample(1, 0, 0, 1, "p101_b4");
      sample(1, 1, 0, 1, "p101_b5");
      sample(1, 0, 0, 1, "p101_b6");
      sample(1, 1, 1, 2, "p101_b7");
      do_clear("clr5");

      // Single-bit pattern; 2-bit counter saturates at 3.
      load(8'b0000_0001, 4'd1, 1'b1, 1'b0, 0, "p1_load");
      sample(1, 1, 1, 1, "sat_1");
      sample(1, 1, 1, 2, "sat_2");
      sample(1, 1, 1, 3, "sat_3");
      sample(1, 1, 1, 3, "sat_4");
      sample(1, 1, 1, 3, "sat_5");
      sample(1, 1, 1, 3, "sat_6");
      do_clear("clr6");
      sample(1, 1, 1, 1, "p1_after_clr");
      sample(1, 0, 0, 1, "p1_zero");
      sample(1, 1, 1, 2, "p1_b2");
      sample(1, 1, 1, 3, "p1_b3");

      // Restore default; count is kept across a valid load.
      load(8'b0001_0101, 4'd5, 1'b1, 1'b0, 3, "def_reload");
      sample(1, 1, 0, 3, "rst_b1");
      sample(1, 0, 0, 3, "rst_b2");
      sample(1, 1, 0, 3, "rst_b3");
      sample(1, 0, 0, 3, "rst_b4");
      #2;
      reset = 1'b0;
      #1;
      check_eq("async_rst.det", 32'(sequence_detected), 32'd0);
      check_eq("async_rst.cnt", 32'(match_count), 32'd0);
      check_eq("async_rst.err", 32'(cfg_err), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      sample(1, 1, 0, 0, "post_b1");
      sample(1, 0, 0, 0, "post_b2");
      sample(1, 1, 0, 0, "post_b3");
      sample(1, 0, 0, 0, "post_b4");
      sample(1, 1, 1, 1, "post_b5");
      sample(0, 0, 0, 1, "post_idle");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
